// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: stall, fetch handshake, redirect channels and BTB update port.
// master = pc_gen, slave = the pipeline/memory side driving it.
interface pc_gen_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REDIR = 2
);
  logic                      stall;
  logic                      fetch_ready;
  logic [NUM_REDIR-1:0]      redir_valid;
  logic [NUM_REDIR*XLEN-1:0] redir_pc;
  logic                      btb_upd_valid;
  logic [XLEN-1:0]           btb_upd_pc;
  logic [XLEN-1:0]           btb_upd_target;
  logic                      btb_upd_taken;
  logic [XLEN-1:0]           pc_out;
  logic                      pc_valid;
  logic                      pred_taken;
  logic                      redir_taken;
  logic [2:0]                redir_src;
  logic                      misalign_err;

  modport master (
    input  stall, fetch_ready, redir_valid, redir_pc,
           btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
    output pc_out, pc_valid, pred_taken, redir_taken, redir_src, misalign_err
  );

  modport slave (
    output stall, fetch_ready, redir_valid, redir_pc,
           btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
    input  pc_out, pc_valid, pred_taken, redir_taken, redir_src, misalign_err
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with prioritised, registered redirects.
// Optional direct-mapped branch-target buffer enabled by defining PCGEN_BTB_EN.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     NUM_REDIR    = 2,
  parameter int unsigned     BTB_DEPTH    = 16
) (
  input  logic      clk,
  input  logic      reset,
  pc_gen_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, ERR} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            pred_q;
  logic            redir_taken_q;
  logic [2:0]      redir_src_q;
  logic            misalign_q;

  logic            redir_any;
  logic [2:0]      redir_idx;
  logic [XLEN-1:0] redir_tgt;
  logic            advance;
  logic            btb_hit;
  logic [XLEN-1:0] next_pc;

  // Lowest set channel index wins; scan from the top so lower indices overwrite.
  always_comb begin
    redir_any = 1'b0;
    redir_idx = 3'd0;
    redir_tgt = '0;
    for (int i = int'(NUM_REDIR) - 1; i >= 0; i--) begin
      if (bus.redir_valid[i]) begin
        redir_any = 1'b1;
        redir_idx = 3'(i);
        redir_tgt = bus.redir_pc[i*XLEN +: XLEN];
      end
    end
  end

  assign advance = pc_valid_q & bus.fetch_ready & ~bus.stall;

`ifdef PCGEN_BTB_EN
  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [BTB_DEPTH-1:0] btb_vld;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [XLEN-1:0]      btb_tgt [BTB_DEPTH];
  logic [IDX_W-1:0]     lk_idx;
  logic [IDX_W-1:0]     up_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic [TAG_W-1:0]     up_tag;
  logic                 unused_upd_lsb;

  assign lk_idx         = pc_q[IDX_W+1:2];
  assign lk_tag         = pc_q[XLEN-1:IDX_W+2];
  assign up_idx         = bus.btb_upd_pc[IDX_W+1:2];
  assign up_tag         = bus.btb_upd_pc[XLEN-1:IDX_W+2];
  assign unused_upd_lsb = ^bus.btb_upd_pc[1:0];

  assign btb_hit = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign next_pc = btb_hit ? btb_tgt[lk_idx] : pc_q + XLEN'(4);

  // Valid bits: set on taken, cleared on not-taken only when the tag matches.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_vld <= '0;
    end else if (bus.btb_upd_valid) begin
      if (bus.btb_upd_taken) begin
        btb_vld[up_idx] <= 1'b1;
      end else if (btb_tag[up_idx] == up_tag) begin
        btb_vld[up_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.btb_upd_valid && bus.btb_upd_taken) begin
      btb_tag[up_idx] <= up_tag;
      btb_tgt[up_idx] <= bus.btb_upd_target;
    end
  end
`else
  logic unused_btb_upd;

  assign unused_btb_upd = ^{bus.btb_upd_valid, bus.btb_upd_pc,
                            bus.btb_upd_target, bus.btb_upd_taken};
  assign btb_hit = 1'b0;
  assign next_pc = pc_q + XLEN'(4);
`endif

  // State and all outputs; a redirect overrides stall, fetch_ready and the ERR freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      pred_q        <= 1'b0;
      redir_taken_q <= 1'b0;
      redir_src_q   <= 3'd0;
      misalign_q    <= 1'b0;
    end else begin
      redir_taken_q <= 1'b0;
      if (redir_any) begin
        pc_q          <= redir_tgt;
        redir_taken_q <= 1'b1;
        redir_src_q   <= redir_idx;
        pred_q        <= 1'b0;
        if (redir_tgt[1:0] != 2'b00) begin
          state      <= ERR;
          pc_valid_q <= 1'b0;
          misalign_q <= 1'b1;
        end else begin
          state      <= RUN;
          pc_valid_q <= 1'b1;
          misalign_q <= 1'b0;
        end
      end else begin
        case (state)
          BOOT: begin
            state      <= RUN;
            pc_valid_q <= 1'b1;
          end
          RUN: begin
            if (advance) begin
              pc_q   <= next_pc;
              pred_q <= btb_hit;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_valid     = pc_valid_q;
  assign bus.pred_taken   = pred_q;
  assign bus.redir_taken  = redir_taken_q;
  assign bus.redir_src    = redir_src_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (BTB expectations follow PCGEN_BTB_EN).
module tb_pc_gen;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_REDIR = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pc_gen_if #(.XLEN(XLEN), .NUM_REDIR(NUM_REDIR)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(32'h100), .NUM_REDIR(NUM_REDIR), .BTB_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    bus.redir_valid = v;
    bus.redir_pc    = {p1, p0};
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc, input logic vld);
    check({tag, ".pc"}, bus.pc_out, pc);
    check({tag, ".valid"}, 32'(bus.pc_valid), 32'(vld));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.fetch_ready = 1'b1;
    redir(2'b00, 32'h0, 32'h0);
    bus.btb_upd_valid = 1'b0;
    bus.btb_upd_pc = '0;
    bus.btb_upd_target = '0;
    bus.btb_upd_taken = 1'b0;
    step();
    step();
    chk_pc("rst", 32'h100, 1'b0);
    check("rst.pred", 32'(bus.pred_taken), 32'h0);
    check("rst.rtaken", 32'(bus.redir_taken), 32'h0);
    check("rst.src", 32'(bus.redir_src), 32'h0);
    check("rst.merr", 32'(bus.misalign_err), 32'h0);

    // BOOT then sequential fetch
    reset = 1'b0;
    step(); chk_pc("run0", 32'h100, 1'b1);
    step(); chk_pc("run1", 32'h104, 1'b1);
    step(); chk_pc("run2", 32'h108, 1'b1);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_pc("stall", 32'h108, 1'b1);
    end
    bus.stall = 1'b0;
    step(); chk_pc("unstall", 32'h10C, 1'b1);

    // Both channels under stall: channel 0 wins, pulse lasts one cycle
    bus.stall = 1'b1;
    redir(2'b11, 32'h400, 32'h800);
    step();
    chk_pc("prio", 32'h400, 1'b1);
    check("prio.rtaken", 32'(bus.redir_taken), 32'h1);
    check("prio.src", 32'(bus.redir_src), 32'h0);
    redir(2'b00, 32'h0, 32'h0);
    step();
    chk_pc("prio_hold", 32'h400, 1'b1);
    check("prio.pulse", 32'(bus.redir_taken), 32'h0);
    bus.stall = 1'b0;

    redir(2'b10, 32'h0, 32'h800);
    step();
    chk_pc("ch1", 32'h800, 1'b1);
    check("ch1.src", 32'(bus.redir_src), 32'h1);
    redir(2'b00, 32'h0, 32'h0);
    step(); chk_pc("ch1_adv", 32'h804, 1'b1);

    // Misaligned redirect freezes fetch until an aligned one
    redir(2'b01, 32'h202, 32'h0);
    step();
    chk_pc("mis", 32'h202, 1'b0);
    check("mis.merr", 32'(bus.misalign_err), 32'h1);
    check("mis.rtaken", 32'(bus.redir_taken), 32'h1);
    redir(2'b00, 32'h0, 32'h0);
    step(); step();
    chk_pc("err_hold", 32'h202, 1'b0);
    check("err_hold.merr", 32'(bus.misalign_err), 32'h1);
    check("err_hold.rtaken", 32'(bus.redir_taken), 32'h0);
    redir(2'b01, 32'h300, 32'h0);
    step();
    chk_pc("err_exit", 32'h300, 1'b1);
    check("err_exit.merr", 32'(bus.misalign_err), 32'h0);
    redir(2'b00, 32'h0, 32'h0);
    step(); chk_pc("err_adv", 32'h304, 1'b1);

    // Wrap modulo 2^32
    redir(2'b01, 32'hFFFF_FFF8, 32'h0);
    step(); chk_pc("wrap0", 32'hFFFF_FFF8, 1'b1);
    redir(2'b00, 32'h0, 32'h0);
    step(); chk_pc("wrap1", 32'hFFFF_FFFC, 1'b1);
    step(); chk_pc("wrap2", 32'h0, 1'b1);
    check("wrap.merr", 32'(bus.misalign_err), 32'h0);
    step(); chk_pc("wrap3", 32'h4, 1'b1);

    reset = 1'b1;
    step(); chk_pc("midrst", 32'h100, 1'b0);
    reset = 1'b0;

    // Redirect while in BOOT goes straight to RUN
    redir(2'b01, 32'h600, 32'h0);
    step();
    chk_pc("boot_redir", 32'h600, 1'b1);
    check("boot_redir.rtaken", 32'(bus.redir_taken), 32'h1);
    redir(2'b00, 32'h0, 32'h0);
    step(); chk_pc("boot_adv", 32'h604, 1'b1);
    bus.fetch_ready = 1'b0;
    step(); chk_pc("nordy", 32'h604, 1'b1);
    bus.fetch_ready = 1'b1;

    // BTB: taken update for 0x110 -> 0x500
    bus.btb_upd_valid = 1'b1;
    bus.btb_upd_pc = 32'h110;
    bus.btb_upd_target = 32'h500;
    bus.btb_upd_taken = 1'b1;
    redir(2'b01, 32'h10C, 32'h0);
    step();
    chk_pc("btb0", 32'h10C, 1'b1);
    bus.btb_upd_valid = 1'b0;
    redir(2'b00, 32'h0, 32'h0);
    step();
    chk_pc("btb1", 32'h110, 1'b1);
    check("btb1.pred", 32'(bus.pred_taken), 32'h0);
    step();
`ifdef PCGEN_BTB_EN
    chk_pc("btb2", 32'h500, 1'b1);
    check("btb2.pred", 32'(bus.pred_taken), 32'h1);
`else
    chk_pc("btb2", 32'h114, 1'b1);
    check("btb2.pred", 32'(bus.pred_taken), 32'h0);
`endif

    // Not-taken update clears the entry; refetch falls through
    bus.btb_upd_valid = 1'b1;
    bus.btb_upd_taken = 1'b0;
    redir(2'b01, 32'h110, 32'h0);
    step();
    chk_pc("nt0", 32'h110, 1'b1);
    check("nt0.pred", 32'(bus.pred_taken), 32'h0);
    bus.btb_upd_valid = 1'b0;
    redir(2'b00, 32'h0, 32'h0);
    step();
    chk_pc("nt1", 32'h114, 1'b1);
    check("nt1.pred", 32'(bus.pred_taken), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch program-counter generator for the 5-stage pipeline; successor to the single-jump PC register.
- Supplies the fetch address to instruction memory through a valid/ready handshake.
- Accepts stall from hazard logic and N prioritised redirect channels (e.g. trap, EX branch, ID jump).
- All redirects are registered; there is no combinational path from redirect inputs to pc_out.
- Optional branch-target buffer predicts taken branches at fetch.

Parameters:
XLEN, 32, PC/address width in bits (>= 8)
RESET_VECTOR, 0, PC value loaded on reset; must be 4-byte aligned
NUM_REDIR, 2, number of redirect channels (1..8); index 0 = highest priority
BTB_DEPTH, 16, BTB entries, power of 2 (used only with PCGEN_BTB_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold current PC (hazard stall)
fetch_ready  in  1  instruction memory accepts pc_out this cycle
redir_valid  in  NUM_REDIR  per-channel redirect request
redir_pc  in  NUM_REDIR*XLEN  per-channel target; channel i at bits [i*XLEN +: XLEN]
btb_upd_valid  in  1  BTB update strobe from EX
btb_upd_pc  in  XLEN  branch instruction address
btb_upd_target  in  XLEN  resolved target
btb_upd_taken  in  1  1 = branch taken, 0 = not taken
pc_out  out  XLEN  current fetch address
pc_valid  out  1  pc_out is a valid fetch request
pred_taken  out  1  pc_out was reached through a BTB prediction
redir_taken  out  1  one-cycle pulse: redirect applied on the previous edge
redir_src  out  3  index of the channel applied (valid while redir_taken=1)
misalign_err  out  1  redirect target was not 4-byte aligned

Behaviour:
- Reset (synchronous, dominates everything):
  - pc_out=RESET_VECTOR; pc_valid, pred_taken, redir_taken, misalign_err=0; redir_src=0.
  - State=BOOT. BTB valid bits cleared (with macro).
- States:
  - BOOT: pc_valid=0. Go to RUN on the next edge. pc_out stays RESET_VECTOR.
  - RUN: pc_valid=1.
  - ERR: pc_valid=0, misalign_err=1.
- Advance condition in RUN: pc_valid & fetch_ready & ~stall.
  - On advance: pc_out <= next_pc, where next_pc = BTB target on hit (with macro), else pc_out+4.
  - Addition wraps modulo 2^XLEN: all-ones-minus-3 + 4 -> 0, with no error.
- Hold: no advance and no redirect -> pc_out, pred_taken unchanged.
- Redirect selection:
  - Any redir_valid bit set -> lowest set index wins.
  - Applies in BOOT, RUN and ERR, and overrides stall and fetch_ready.
  - Latency: 1 edge. pc_out=target, redir_taken=1, redir_src=index, pred_taken=0.
  - Redirect arriving in BOOT moves the state to RUN.
- Misaligned redirect: winning target with bits[1:0]!=0 -> state ERR, pc_out=target, misalign_err=1, redir_taken=1.
  - ERR exits only through an aligned redirect (-> RUN, misalign_err=0) or reset.
  - Advance conditions are ignored in ERR.
- redir_taken is low on every edge without a redirect.
- Simultaneous redirect and advance: redirect wins; sequential next_pc is discarded.
- Reset mid-operation (any state): outputs return to reset values on that edge.

Optional Feature:
PCGEN_BTB_EN
- Defined:
  - Direct-mapped BTB of BTB_DEPTH entries.
  - Index = pc[log2(BTB_DEPTH)+1:2]; tag = remaining upper PC bits; each entry holds valid, tag, target.
  - Lookup is combinational on pc_out. Hit = valid & tag match.
  - On hit during advance: next_pc = target; pred_taken <= 1 with the new pc_out. Otherwise pred_taken <= 0 on advance.
  - Update on btb_upd_valid:
    - taken=1 writes valid, tag and target.
    - taken=0 clears valid only if the tag matches.
    - An update to the entry currently being looked up takes effect from the next cycle's lookup.
- Undefined:
  - No BTB storage; pred_taken tied 0; btb_upd_* ignored; next_pc = pc_out+4.

Test Plan:
- Reset RESET_VECTOR=0x100, fetch_ready=1 -> BOOT cycle pc_valid=0; then pc_out 0x100, 0x104, 0x108 on consecutive cycles.
- stall=1 for 3 cycles at 0x108 -> pc_out holds 0x108; stall=0 -> 0x10C next edge.
- redir_valid=2'b11, ch0=0x400, ch1=0x800, with stall=1 -> next pc_out=0x400, redir_taken=1, redir_src=0 for exactly one cycle.
- Redirect to 0x202 -> misalign_err=1, pc_valid=0, PC frozen despite fetch_ready; redirect to 0x300 -> RUN, pc_out=0x300, err cleared.
- pc_out=0xFFFFFFFC, advance -> pc_out=0x0, no error; assert reset mid-stream -> pc_out=RESET_VECTOR, pc_valid=0 next edge.
- Macro on: update pc 0x110 -> 0x500 taken; fetch from 0x10C -> 0x110 -> 0x500 with pred_taken=1. Not-taken update, re-fetch 0x110 -> 0x114. Macro off: 0x110 -> 0x114, pred_taken=0.
